// File: rtl/sw_pkg.sv
// Shared types and default scores for the tiled Smith-Waterman engine.
// Used by sw_pe and sw_tiled.
package sw_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_TLOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } sw_state_e;

    typedef logic [1:0] nt_t;

    localparam int SW_MATCH    = 8;
    localparam int SW_MISMATCH = -5;
    localparam int SW_OPEN     = -7;
    localparam int SW_EXT      = -3;

    function automatic int num_pass(input int seq_len, input int num_pe);
        return seq_len / num_pe;
    endfunction

endpackage

// File: rtl/sw_pe.sv
// One systolic cell: affine-gap recurrences for a fixed target column.
// SW_POS_EN adds tracking of the row of the local best score.
module sw_pe
    import sw_pkg::*;
#(
    parameter int SCORE_W  = 12,
    parameter int IW       = 8,
    parameter int MATCH    = SW_MATCH,
    parameter int MISMATCH = SW_MISMATCH,
    parameter int OPEN     = SW_OPEN,
    parameter int EXT      = SW_EXT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  nt_t                t_in,
    output nt_t                t_q,
    input  logic               v_in,
    input  nt_t                s_in,
    input  logic [SCORE_W-1:0] h_in,
    input  logic [SCORE_W-1:0] e_in,
    output logic               v_out,
    output nt_t                s_out,
    output logic [SCORE_W-1:0] h_out,
    output logic [SCORE_W-1:0] e_out,
`ifdef SW_POS_EN
    output logic [IW-1:0]      best_i,
`endif
    output logic [SCORE_W-1:0] best
);

    typedef logic signed [SCORE_W:0] sc_t;

    localparam sc_t C_MATCH = sc_t'(MATCH);
    localparam sc_t C_MISM  = sc_t'(MISMATCH);
    localparam sc_t C_OPEN  = sc_t'(OPEN);
    localparam sc_t C_EXT   = sc_t'(EXT);

    function automatic sc_t ext(input logic [SCORE_W-1:0] v);
        return sc_t'({1'b0, v});
    endfunction

    function automatic sc_t smax(input sc_t a, input sc_t b);
        return (a > b) ? a : b;
    endfunction

    logic [SCORE_W-1:0] h_up, f_up, h_dg;
    logic [IW-1:0]      row;
    sc_t e_v, f_v, d_v, h_v, e_cl, f_cl;
    logic [SCORE_W-1:0] h_n;

    // E/F clamp at 0 keeps H exact because H already floors at 0.
    always_comb begin
        e_v  = smax(ext(h_in) + C_OPEN, ext(e_in) + C_EXT);
        f_v  = smax(ext(h_up) + C_OPEN, ext(f_up) + C_EXT);
        e_cl = e_v[SCORE_W] ? '0 : e_v;
        f_cl = f_v[SCORE_W] ? '0 : f_v;
        d_v  = ext(h_dg) + ((s_in == t_q) ? C_MATCH : C_MISM);
        h_v  = smax(smax(d_v, e_cl), f_cl);
        h_n  = h_v[SCORE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            t_q   <= '0;
            v_out <= 1'b0;
            s_out <= '0;
            h_out <= '0;
            e_out <= '0;
            h_up  <= '0;
            f_up  <= '0;
            h_dg  <= '0;
            row   <= '0;
            best  <= '0;
`ifdef SW_POS_EN
            best_i <= '0;
`endif
        end else if (load) begin
            t_q   <= t_in;
            v_out <= 1'b0;
            h_out <= '0;
            e_out <= '0;
            h_up  <= '0;
            f_up  <= '0;
            h_dg  <= '0;
            row   <= '0;
            best  <= '0;
`ifdef SW_POS_EN
            best_i <= '0;
`endif
        end else begin
            v_out <= v_in;
            s_out <= s_in;
            if (v_in) begin
                h_out <= h_n;
                e_out <= e_cl[SCORE_W-1:0];
                h_up  <= h_n;
                f_up  <= f_cl[SCORE_W-1:0];
                h_dg  <= h_in;
                row   <= row + 1'b1;
                if (h_n > best) begin
                    best <= h_n;
`ifdef SW_POS_EN
                    best_i <= row;
`endif
                end
            end
        end
    end

endmodule

// File: rtl/sw_tiled.sv
// Tiled Smith-Waterman engine: buffers s/t, runs SEQ_LEN/NUM_PE passes.
// Define SW_POS_EN to add max_i/max_j best-cell coordinate outputs.
module sw_tiled
    import sw_pkg::*;
#(
    parameter int SEQ_LEN  = 256,
    parameter int NUM_PE   = 64,
    parameter int SCORE_W  = 12,
    parameter int MATCH    = SW_MATCH,
    parameter int MISMATCH = SW_MISMATCH,
    parameter int OPEN     = SW_OPEN,
    parameter int EXT      = SW_EXT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 data_s,
    input  logic [1:0]                 data_t,
    output logic                       finish,
`ifdef SW_POS_EN
    output logic [$clog2(SEQ_LEN)-1:0] max_i,
    output logic [$clog2(SEQ_LEN)-1:0] max_j,
`endif
    output logic [SCORE_W-1:0]         max
);

    localparam int IW       = $clog2(SEQ_LEN);
    localparam int PIW      = $clog2(NUM_PE);
    localparam int NUM_PASS = num_pass(SEQ_LEN, NUM_PE);
    localparam int PPW      = $clog2(NUM_PASS + 1);

    if (SEQ_LEN % NUM_PE != 0) begin : g_len_chk
        $error("SEQ_LEN must be a multiple of NUM_PE");
    end
    if ((2 ** SCORE_W) <= MATCH * SEQ_LEN) begin : g_w_chk
        $error("SCORE_W too narrow for MATCH*SEQ_LEN");
    end

    sw_state_e state, state_n;
    logic [IW-1:0]  cnt, cnt_n, wr_idx, t_idx;
    logic [PPW-1:0] p, p_n;
    logic [PIW-1:0] d;
    logic           accept;

    nt_t                s_buf   [SEQ_LEN];
    nt_t                t_buf   [SEQ_LEN];
    logic [2*SCORE_W-1:0] col_buf [SEQ_LEN];

    logic               v_ch [NUM_PE+1];
    nt_t                s_ch [NUM_PE+1];
    nt_t                t_ch [NUM_PE+1];
    logic [SCORE_W-1:0] h_ch [NUM_PE+1];
    logic [SCORE_W-1:0] e_ch [NUM_PE+1];
    logic [SCORE_W-1:0] pe_best [NUM_PE];
`ifdef SW_POS_EN
    logic [IW-1:0]      pe_bi [NUM_PE];
`endif

    assign in_ready = (state == S_IDLE) || (state == S_LOAD) ||
                      (state == S_DONE);
    assign accept   = in_valid && in_ready;
    assign finish   = (state == S_DONE);
    assign d        = cnt[PIW-1:0];
    // Columns are shifted in highest-first so PE k ends with t[p*NUM_PE+k].
    assign t_idx    = IW'(int'(p) * NUM_PE + NUM_PE - 1 - int'(cnt));

    assign v_ch[0] = (state == S_STREAM);
    assign s_ch[0] = s_buf[cnt];
    assign t_ch[0] = t_buf[t_idx];
    assign h_ch[0] = (p == '0) ? '0 : col_buf[cnt][2*SCORE_W-1:SCORE_W];
    assign e_ch[0] = (p == '0) ? '0 : col_buf[cnt][SCORE_W-1:0];

    for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
        sw_pe #(
            .SCORE_W (SCORE_W),
            .IW      (IW),
            .MATCH   (MATCH),
            .MISMATCH(MISMATCH),
            .OPEN    (OPEN),
            .EXT     (EXT)
        ) u_pe (
            .clk   (clk),
            .reset (reset),
            .load  (state == S_TLOAD),
            .t_in  (t_ch[k]),
            .t_q   (t_ch[k+1]),
            .v_in  (v_ch[k]),
            .s_in  (s_ch[k]),
            .h_in  (h_ch[k]),
            .e_in  (e_ch[k]),
            .v_out (v_ch[k+1]),
            .s_out (s_ch[k+1]),
            .h_out (h_ch[k+1]),
            .e_out (e_ch[k+1]),
`ifdef SW_POS_EN
            .best_i(pe_bi[k]),
`endif
            .best  (pe_best[k])
        );
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        p_n     = p;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    state_n = S_LOAD;
                    cnt_n   = IW'(1);
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (cnt == IW'(SEQ_LEN - 1)) begin
                        state_n = S_TLOAD;
                        cnt_n   = '0;
                        p_n     = '0;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_TLOAD: begin
                if (cnt == IW'(NUM_PE - 1)) begin
                    state_n = S_STREAM;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_STREAM: begin
                if (cnt == IW'(SEQ_LEN - 1)) begin
                    state_n = S_DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt == IW'(NUM_PE - 1)) begin
                    cnt_n   = '0;
                    p_n     = p + 1'b1;
                    state_n = (p == PPW'(NUM_PASS - 1)) ? S_DONE : S_TLOAD;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            p      <= '0;
            wr_idx <= '0;
            max    <= '0;
`ifdef SW_POS_EN
            max_i  <= '0;
            max_j  <= '0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            p     <= p_n;
            if (state == S_TLOAD) begin
                wr_idx <= '0;
            end else if (v_ch[NUM_PE]) begin
                wr_idx <= wr_idx + 1'b1;
            end
            // PE d is final by drain cycle d; strict > keeps lowest j, then i.
            if (accept && state != S_LOAD) begin
                max <= '0;
`ifdef SW_POS_EN
                max_i <= '0;
                max_j <= '0;
`endif
            end else if (state == S_DRAIN && pe_best[d] > max) begin
                max <= pe_best[d];
`ifdef SW_POS_EN
                max_i <= pe_bi[d];
                max_j <= IW'(int'(p) * NUM_PE + int'(cnt));
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s_buf[cnt] <= data_s;
            t_buf[cnt] <= data_t;
        end
        if (v_ch[NUM_PE]) begin
            col_buf[wr_idx] <= {h_ch[NUM_PE], e_ch[NUM_PE]};
        end
    end

endmodule

// File: tb/tb_sw_tiled.sv
// Directed bench for sw_tiled at SEQ_LEN=8, NUM_PE=4.
// Position outputs are checked when SW_POS_EN is defined.
module tb_sw_tiled;

    localparam int L   = 8;
    localparam int NPE = 4;
    localparam int W   = 12;
    localparam int LAT = (L / NPE) * (L + 2 * NPE);

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [1:0]   data_s;
    logic [1:0]   data_t;
    logic         in_ready;
    logic         finish;
    logic [W-1:0] max;
`ifdef SW_POS_EN
    logic [2:0]   max_i;
    logic [2:0]   max_j;
`endif

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sw_tiled #(
        .SEQ_LEN(L),
        .NUM_PE (NPE),
        .SCORE_W(W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_s  (data_s),
        .data_t  (data_t),
        .finish  (finish),
`ifdef SW_POS_EN
        .max_i   (max_i),
        .max_j   (max_j),
`endif
        .max     (max)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] s, input logic [15:0] t,
                        input bit bub);
        for (int k = 0; k < L; k++) begin
            if (bub) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            data_s   = s[2*k +: 2];
            data_t   = t[2*k +: 2];
            @(posedge clk);
            #1;
            if (k == 0) chk("fin_drop", {31'b0, finish}, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] s,
                       input logic [15:0] t, input bit bub,
                       input int exp_max, input int exp_i, input int exp_j);
        int n;
        send(s, t, bub);
        n = 0;
        while (!finish && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, LAT);
        chk({tag, "_max"}, {20'b0, max}, exp_max);
`ifdef SW_POS_EN
        chk({tag, "_i"}, {29'b0, max_i}, exp_i);
        chk({tag, "_j"}, {29'b0, max_j}, exp_j);
`else
        if (exp_i != exp_j) $display("note: %s pos %0d,%0d", tag, exp_i, exp_j);
`endif
    endtask

    // A = 2'b00, C = 2'b01; symbol k sits in bits [2k+1:2k].
    localparam logic [15:0] ALL_A = 16'h0000;
    localparam logic [15:0] ALL_C = 16'h5555;
    localparam logic [15:0] T_MIS = 16'h0100;

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        data_s   = '0;
        data_t   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_finish", {31'b0, finish}, 0);
        chk("rst_max", {20'b0, max}, 0);
        chk("rst_ready", {31'b0, in_ready}, 1);
        reset = 1'b0;

        run("t1", ALL_A, ALL_A, 1'b0, 64, 7, 7);
        chk("done_ready", {31'b0, in_ready}, 1);
        run("t2", ALL_A, ALL_C, 1'b0, 0, 0, 0);
        run("t3", ALL_A, T_MIS, 1'b0, 51, 7, 7);
        run("t6", ALL_A, ALL_A, 1'b0, 64, 7, 7);
        run("t4", ALL_A, ALL_A, 1'b1, 64, 7, 7);

        send(ALL_A, ALL_A, 1'b0);
        repeat (22) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_finish", {31'b0, finish}, 0);
        chk("mid_max", {20'b0, max}, 0);
        chk("mid_ready", {31'b0, in_ready}, 1);

        run("t5", ALL_A, T_MIS, 1'b0, 51, 7, 7);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
